// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, no-register address and clear-sequencer state encoding for reg_file_2w2r
package rf_pkg;
  localparam int RF_DATA_WID = 32;
  localparam int RF_ADDR_WID = 4;
  localparam logic [RF_ADDR_WID-1:0] RNONE = '1;
  localparam logic [0:0] RF_CLEAR = 1'b0;
  localparam logic [0:0] RF_RUN = 1'b1;
endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: post-reset clear sweep (clk_i, rst_ni in; clr_we_o/clr_addr_o zero one register per cycle, ready_o once done)
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int ADDR_WID       = RF_ADDR_WID,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic                clr_we_o,
  output logic [ADDR_WID-1:0] clr_addr_o,
  output logic                ready_o
);
  localparam logic [ADDR_WID-1:0] LAST = ADDR_WID'(2**ADDR_WID - 2);
  logic [0:0] state_q, state_d;
  logic [ADDR_WID-1:0] ptr_q, ptr_d;
  logic ready_q, ready_d;
  logic done;
  assign done = !CLEAR_ON_RESET || ptr_q == LAST;
  always_comb begin
    state_d = (state_q == RF_CLEAR && done) ? RF_RUN : state_q;
    ptr_d   = (state_q == RF_CLEAR) ? ptr_q + 1'b1 : ptr_q;
    ready_d = ready_q || (state_q == RF_CLEAR && done);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RF_CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end
  assign clr_we_o   = CLEAR_ON_RESET && state_q == RF_CLEAR;
  assign clr_addr_o = ptr_q;
  assign ready_o    = ready_q;
endmodule

// File: rtl/reg_file_2w2r.sv
// reg_file_2w2r: 2-read/2-write register file (CLK, RST_N; srcA/srcB -> valA/valB; destE/valE and destM/valM writes, M wins; ready)
module reg_file_2w2r
  import rf_pkg::*;
#(
  parameter int DATA_WID       = RF_DATA_WID,
  parameter int ADDR_WID       = RF_ADDR_WID,
  parameter bit BYPASS         = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [ADDR_WID-1:0] srcA,
  input  logic [ADDR_WID-1:0] srcB,
  output logic [DATA_WID-1:0] valA,
  output logic [DATA_WID-1:0] valB,
  input  logic [ADDR_WID-1:0] destE,
  input  logic [DATA_WID-1:0] valE,
  input  logic [ADDR_WID-1:0] destM,
  input  logic [DATA_WID-1:0] valM,
  output logic                ready
);
  localparam logic [ADDR_WID-1:0] NONE = '1;
  localparam int DEPTH = 2**ADDR_WID - 1;
  logic [DATA_WID-1:0] mem_q [DEPTH];
  logic clr_we, we_e, we_m;
  logic [ADDR_WID-1:0] clr_addr;
  rf_clear_seq #(.ADDR_WID(ADDR_WID), .CLEAR_ON_RESET(CLEAR_ON_RESET)) u_seq (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr),
    .ready_o   (ready)
  );
  assign we_m = RST_N && ready && destM != NONE;
  assign we_e = RST_N && ready && destE != NONE && !(we_m && destM == destE);
  always_ff @(posedge CLK) begin
    if (RST_N && clr_we) mem_q[clr_addr] <= '0;
    else begin
      if (we_e) mem_q[destE] <= valE;
      if (we_m) mem_q[destM] <= valM;
    end
  end
  function automatic logic [DATA_WID-1:0] rd(input logic [ADDR_WID-1:0] s);
    return (!ready || s == NONE) ? '0 :
           (BYPASS && destM != NONE && s == destM) ? valM :
           (BYPASS && destE != NONE && s == destE) ? valE : mem_q[s];
  endfunction
  assign valA = rd(srcA);
  assign valB = rd(srcB);
endmodule

// File: tb/tb_reg_file_2w2r.sv
// tb_reg_file_2w2r: directed bench with a cycle-level model comparing bypass and non-bypass register files
module tb_reg_file_2w2r;
  logic CLK = 1'b0, RST_N = 1'b0;
  logic [3:0] srcA = 4'd0, srcB = 4'd0, destE = 4'hF, destM = 4'hF;
  logic [31:0] valE = '0, valM = '0;
  logic [31:0] a_byp, b_byp, a_nb, b_nb;
  logic rdy_byp, rdy_nb;
  int n_cmp = 0, n_bad = 0;
  bit started = 1'b0;
  logic [31:0] m [15];
  bit m_ready = 1'b0;
  int hi = 0;
  int timeout;

  always #5 CLK = ~CLK;

  reg_file_2w2r #(.BYPASS(1'b1)) u_byp (
    .CLK(CLK), .RST_N(RST_N), .srcA(srcA), .srcB(srcB), .valA(a_byp), .valB(b_byp),
    .destE(destE), .valE(valE), .destM(destM), .valM(valM), .ready(rdy_byp));
  reg_file_2w2r #(.BYPASS(1'b0)) u_nb (
    .CLK(CLK), .RST_N(RST_N), .srcA(srcA), .srcB(srcB), .valA(a_nb), .valB(b_nb),
    .destE(destE), .valE(valE), .destM(destM), .valM(valM), .ready(rdy_nb));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ready after 15 clock edges with RST_N high; file is all zeros at that point; M beats E.
  always @(posedge CLK) begin
    if (!RST_N) begin
      m_ready = 1'b0;
      hi = 0;
    end else if (m_ready) begin
      if (destE != 4'hF) m[destE] = valE;
      if (destM != 4'hF) m[destM] = valM;
    end else begin
      hi++;
      if (hi == 15) begin
        m_ready = 1'b1;
        for (int i = 0; i < 15; i++) m[i] = '0;
      end
    end
  end

  function automatic logic [31:0] expect_rd(input logic [3:0] s, input bit byp);
    if (!m_ready || s == 4'hF) return '0;
    if (byp && destM != 4'hF && s == destM) return valM;
    if (byp && destE != 4'hF && s == destE) return valE;
    return m[s];
  endfunction

  always @(negedge CLK) if (started) begin
    chk("ready_byp", {31'd0, rdy_byp}, {31'd0, m_ready});
    chk("ready_nb", {31'd0, rdy_nb}, {31'd0, m_ready});
    chk("valA_byp", a_byp, expect_rd(srcA, 1'b1));
    chk("valB_byp", b_byp, expect_rd(srcB, 1'b1));
    chk("valA_nb", a_nb, expect_rd(srcA, 1'b0));
    chk("valB_nb", b_nb, expect_rd(srcB, 1'b0));
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    destE = 4'hF;
    destM = 4'hF;
  endtask

  task automatic count_ready(input string name);
    for (int k = 0; k <= 15; k++) begin
      srcA = 4'(k % 15);
      #1;
      chk({name, "_ready"}, {31'd0, rdy_byp}, (k == 15) ? 32'd1 : 32'd0);
      if (k < 15) chk({name, "_valA0"}, a_byp, 32'd0);
      if (k < 15) step();
    end
  endtask

  initial begin
    logic [31:0] lit [15];
    // Test 1: reset, clear sweep timing, all zero afterwards
    RST_N = 1'b0;
    step();
    step();
    started = 1'b1;
    RST_N = 1'b1;
    count_ready("t1");
    for (int k = 0; k < 15; k++) begin
      srcA = 4'(k);
      srcB = 4'(14 - k);
      #1;
      chk("t1_zeroA", a_nb, 32'd0);
      step();
    end
    // Test 2: E then M writes, read back next cycle
    destE = 4'd3; valE = 32'h30;
    step();
    idle(); destM = 4'd5; valM = 32'h55;
    step();
    idle(); srcA = 4'd3; srcB = 4'd5;
    #1;
    chk("t2_A3", a_nb, 32'h30);
    chk("t2_B5", b_nb, 32'h55);
    step();
    // Test 3: same destination, M wins; bypass sees M in the write cycle
    destE = 4'd7; valE = 32'h70; destM = 4'd7; valM = 32'h77; srcA = 4'd7; srcB = 4'd7;
    #1;
    chk("t3_byp_same", a_byp, 32'h77);
    chk("t3_nb_old", a_nb, 32'h0);
    step();
    idle();
    #1;
    chk("t3_reg7", a_nb, 32'h77);
    chk("t3_reg7B", b_byp, 32'h77);
    // Test 4: non-bypass returns old value in the write cycle
    destE = 4'd2; valE = 32'hAB; srcA = 4'd2;
    #1;
    chk("t4_nb_old", a_nb, 32'h0);
    chk("t4_byp_new", a_byp, 32'hAB);
    step();
    idle();
    #1;
    chk("t4_nb_new", a_nb, 32'hAB);
    // Test 5: RNONE writes change nothing, RNONE reads zero
    destE = 4'hF; valE = 32'hFF; destM = 4'hF; valM = 32'hEE; srcA = 4'hF; srcB = 4'hF;
    #1;
    chk("t5_rnoneA", a_byp, 32'h0);
    chk("t5_rnoneB", b_nb, 32'h0);
    step();
    for (int k = 0; k < 15; k++) lit[k] = '0;
    lit[2] = 32'hAB; lit[3] = 32'h30; lit[5] = 32'h55; lit[7] = 32'h77;
    for (int k = 0; k < 15; k++) begin
      srcA = 4'(k);
      #1;
      chk("t5_keep", a_nb, lit[k]);
      step();
    end
    // Test 6: fill, reset, abort clear at cycle 6, restart, writes during clear dropped
    for (int k = 0; k < 15; k++) begin
      if (k % 2 == 0) begin destE = 4'(k); valE = 32'(10 * k); end
      else begin destM = 4'(k); valM = 32'(10 * k); end
      step();
      idle();
    end
    srcA = 4'd14;
    #1;
    chk("t6_fill14", a_nb, 32'd140);
    RST_N = 1'b0;
    destE = 4'd1; valE = 32'h1111;
    step();
    RST_N = 1'b1;
    for (int k = 0; k < 6; k++) begin
      destE = 4'(k); valE = 32'hDEAD0000 | 32'(k);
      step();
    end
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    destM = 4'd9; valM = 32'hBEEF;
    count_ready("t6");
    idle();
    for (int k = 0; k < 15; k++) begin
      srcB = 4'(k);
      #1;
      chk("t6_zeroB", b_byp, 32'd0);
      step();
    end
    // Ready and read at the very edge of readiness, bounded wait
    timeout = 0;
    while (!rdy_byp && timeout < 50) begin step(); timeout++; end
    chk("final_ready_bound", {31'd0, rdy_byp}, 32'd1);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
